lcd_cmd_sequencer: RTL

//  Upstream feeder for the LCD controller. Buffers host commands in a FIFO and

---
 rtl/lcd_cmd_sequencer_if.sv | 32 +++
 rtl/lcd_cmd_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// Host-side and controller-side signals of the LCD command sequencer, bundled for port use.
// The slave modport is the sequencer; the master modport is the host/controller environment.
interface lcd_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          host_valid;
  logic [3:0]    host_cmd;
  logic          host_ready;
  logic          ctrl_busy;
  logic          ctrl_done;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [LW-1:0] fifo_level;
  logic [7:0]    issued_cnt;
  logic          err_illegal;
  logic          err_timeout;
  logic          seq_done;

  modport master (
    output host_valid, host_cmd, ctrl_busy, ctrl_done,
    input  host_ready, cmd, cmd_valid, fifo_level, issued_cnt,
           err_illegal, err_timeout, seq_done
  );

  modport slave (
    input  host_valid, host_cmd, ctrl_busy, ctrl_done,
    output host_ready, cmd, cmd_valid, fifo_level, issued_cnt,
           err_illegal, err_timeout, seq_done
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the LCD controller,
// closing the session after the first WRITE (cmd 0) completes or times out.
module lcd_cmd_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input logic               clk,
  input logic               rst,
  lcd_cmd_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_WAITD,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          closed_q, closed_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    issued_q, issued_d;
  logic          err_illegal_q, err_illegal_d;
  logic          err_timeout_q, err_timeout_d;
  logic          seq_done_q, seq_done_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       full;
  logic       empty;
  logic       host_ready;
  logic       push;
  logic       push_legal;
  logic       pop;
  logic [2:0] head;

  // Ready uses the pre-pop level, so a full FIFO refuses a push even when it pops.
  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign host_ready = !full && !closed_q;
  assign push       = bus.host_valid && host_ready;
  assign push_legal = push && !bus.host_cmd[3];
  assign head       = mem_q[rd_ptr_q];
  assign pop        = (state_q == S_IDLE) && !empty && !bus.ctrl_busy;

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    closed_d      = closed_q;
    level_d       = level_q;
    err_illegal_d = push && bus.host_cmd[3];
    if (push_legal) begin
      mem_d[wr_ptr_q] = bus.host_cmd[2:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (bus.host_cmd == 4'd0) begin
        closed_d = 1'b1;
      end
    end
    case ({push_legal, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    cmd_d         = cmd_q;
    cmd_valid_d   = 1'b0;
    issued_d      = issued_q;
    timer_d       = timer_q;
    err_timeout_d = err_timeout_q;
    seq_done_d    = seq_done_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rd_ptr_d    = rd_ptr_q + AW'(1);
          cmd_d       = {1'b0, head};
          cmd_valid_d = 1'b1;
          timer_d     = '0;
          if (issued_q != '1) begin
            issued_d = issued_q + 8'd1;
          end
          state_d = (head == 3'd0) ? S_WAITD : S_GUARD;
        end
      end
      // Controller busy lags the strobe by a cycle; skip one IDLE evaluation.
      S_GUARD: state_d = S_IDLE;
      S_WAITD: begin
        if (bus.ctrl_done) begin
          seq_done_d = 1'b1;
          state_d    = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          seq_done_d    = 1'b1;
          state_d       = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      closed_q      <= 1'b0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      issued_q      <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      seq_done_q    <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      closed_q      <= closed_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      issued_q      <= issued_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      seq_done_q    <= seq_done_d;
      timer_q       <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.host_ready  = host_ready;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.fifo_level  = level_q;
  assign bus.issued_cnt  = issued_q;
  assign bus.err_illegal = err_illegal_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.seq_done    = seq_done_q;
endmodule
